// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan controller.
// Latency: none (constants and types only).
// Backpressure: none.
package sevenseg_pkg;

  // Bus word indices
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_DPMASK = 2'd1;
  localparam logic [1:0] ADDR_ENABLE = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // All segments dark (active-low lines driven high)
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Hex glyphs, active-low, bit order {CG,CF,CE,CD,CC,CB,CA}; b and d lowercase
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Position inside a digit slot
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } scan_phase_t;

endpackage

// File: rtl/sevenseg_decoder.sv
// Hex nibble to active-low seven-segment glyph.
// Latency: combinational.
// Backpressure: none.
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Table lookup of the glyph for the nibble
  always_comb begin
    seg_n = SEG_LUT[hex];
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Bus-mapped 8-digit seven-segment scanner with frame-aligned double buffering.
// Latency: ready/rdata 2 edges after sel; display outputs lag scan state by 1 cycle.
// Backpressure: none; one access accepted every cycle, back-to-back sel gives back-to-back ready.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int BLANK    = 16
)
(
  input  logic        CLK100MHZ,
  input  logic        RESET,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic [7:0]  AN
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK);

  // Bus request stage
  logic        acc_vld_q, acc_vld_d;
  logic        acc_we_q, acc_we_d;
  logic [1:0]  acc_addr_q, acc_addr_d;
  logic [31:0] acc_wdata_q, acc_wdata_d;

  // Bus response
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;

  // Shadow (software-visible) and active (displayed) register copies
  logic [31:0] data_sh_q, data_sh_d;
  logic [7:0]  dpm_sh_q, dpm_sh_d;
  logic [7:0]  en_sh_q, en_sh_d;
  logic [31:0] data_act_q, data_act_d;
  logic [7:0]  dpm_act_q, dpm_act_d;
  logic [7:0]  en_act_q, en_act_d;
  logic        pending_q, pending_d;

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;

  // Registered display outputs
  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  logic        slot_wrap;
  logic        commit;
  logic        wr_data, wr_dpm, wr_en;
  logic [3:0]  digit;
  logic [6:0]  glyph;
  scan_phase_t phase;

  // Capture every strobe; it executes on the following edge
  always_comb begin
    acc_vld_d   = sel;
    acc_we_d    = we;
    acc_addr_d  = addr;
    acc_wdata_d = wdata;
  end

  // Register file: shadow writes, frame-boundary commit, pending flag and read mux
  always_comb begin
    wr_data = acc_vld_q && acc_we_q && (acc_addr_q == ADDR_DATA);
    wr_dpm  = acc_vld_q && acc_we_q && (acc_addr_q == ADDR_DPMASK);
    wr_en   = acc_vld_q && acc_we_q && (acc_addr_q == ADDR_ENABLE);

    data_sh_d  = wr_data ? acc_wdata_q       : data_sh_q;
    dpm_sh_d   = wr_dpm  ? acc_wdata_q[7:0]  : dpm_sh_q;
    en_sh_d    = wr_en   ? acc_wdata_q[7:0]  : en_sh_q;

    // Commit copies the pre-write shadow; a coinciding write stays pending
    data_act_d = data_act_q;
    dpm_act_d  = dpm_act_q;
    en_act_d   = en_act_q;
    pending_d  = pending_q;
    if (commit && pending_q) begin
      data_act_d = data_sh_q;
      dpm_act_d  = dpm_sh_q;
      en_act_d   = en_sh_q;
      pending_d  = 1'b0;
    end
    if (wr_data || wr_dpm || wr_en) begin
      pending_d = 1'b1;
    end

    ready_d = acc_vld_q;
    rdata_d = 32'h0;
    if (acc_vld_q && !acc_we_q) begin
      case (acc_addr_q)
        ADDR_DATA:   rdata_d = data_sh_q;
        ADDR_DPMASK: rdata_d = {24'h0, dpm_sh_q};
        ADDR_ENABLE: rdata_d = {24'h0, en_sh_q};
        default:     rdata_d = {28'h0, pending_q, idx_q};
      endcase
    end
  end

  // Bus stage and register file state
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      acc_vld_q   <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= 2'd0;
      acc_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      ready_q     <= 1'b0;
      data_sh_q   <= 32'h0;
      dpm_sh_q    <= 8'h00;
      en_sh_q     <= 8'hFF;
      data_act_q  <= 32'h0;
      dpm_act_q   <= 8'h00;
      en_act_q    <= 8'hFF;
      pending_q   <= 1'b0;
    end else begin
      acc_vld_q   <= acc_vld_d;
      acc_we_q    <= acc_we_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      data_sh_q   <= data_sh_d;
      dpm_sh_q    <= dpm_sh_d;
      en_sh_q     <= en_sh_d;
      data_act_q  <= data_act_d;
      dpm_act_q   <= dpm_act_d;
      en_act_q    <= en_act_d;
      pending_q   <= pending_d;
    end
  end

  // Scan state register: slot counter and digit index
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      cnt_q <= '0;
      idx_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Scan next state: count through the slot, advance digit on wrap; frame ends on 7->0
  always_comb begin
    slot_wrap = (cnt_q == CNT_LAST);
    commit    = slot_wrap && (idx_q == 3'd7);
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_wrap) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Active nibble of the digit currently being scanned
  always_comb begin
    digit = data_act_q[{idx_q, 2'b00} +: 4];
  end

  sevenseg_decoder u_decoder (
    .hex   (digit),
    .seg_n (glyph)
  );

  // Scan outputs: blank at slot start, then light the enabled digit
  always_comb begin
    phase = (cnt_q < BLANK_CNT) ? PH_BLANK : PH_SHOW;
    an_d  = 8'hFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (phase == PH_SHOW && en_act_q[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = glyph;
      dp_d        = ~dpm_act_q[idx_q];
    end
  end

  // Display output registers
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      an_q  <= 8'hFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign AN    = an_q;
  assign DP    = dp_q;
  assign CA    = seg_q[0];
  assign CB    = seg_q[1];
  assign CC    = seg_q[2];
  assign CD    = seg_q[3];
  assign CE    = seg_q[4];
  assign CF    = seg_q[5];
  assign CG    = seg_q[6];

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl with SCAN_DIV=4, BLANK=1.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_sevenseg_scan_ctrl;

  localparam int SD    = 4;
  localparam int BL    = 1;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        ca, cb, cc, cd, ce, cf, cg, dp;
  logic [7:0]  an;
  logic [6:0]  seg;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(.SCAN_DIV(SD), .BLANK(BL)) dut (
    .CLK100MHZ (clk),
    .RESET     (rst),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .CA        (ca),
    .CB        (cb),
    .CC        (cc),
    .CD        (cd),
    .CE        (ce),
    .CF        (cf),
    .CG        (cg),
    .DP        (dp),
    .AN        (an)
  );

  assign seg = {cg, cf, ce, cd, cc, cb, ca};

  int errors = 0;
  int checks = 0;

  // Lit segments (active-high, gfedcba) of the usual hex glyphs
  logic [6:0] glyph_on [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] glyph(input logic [3:0] h);
    return ~glyph_on[h];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_t;
  bit          m_valid = 1'b0;
  logic [31:0] m_data_sh, m_data_act;
  logic [7:0]  m_dpm_sh, m_dpm_act, m_en_sh, m_en_act;
  bit          m_pend;
  bit          q_vld, q_we;
  logic [1:0]  q_addr;
  logic [31:0] q_wdata;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_ready, exp_rd;
  logic [31:0] exp_rdata;

  always @(posedge clk) begin
    int slot;
    int d;
    if (rst) begin
      m_t = 0; m_valid = 1'b1;
      m_data_sh = 32'h0; m_data_act = 32'h0;
      m_dpm_sh = 8'h00; m_dpm_act = 8'h00;
      m_en_sh = 8'hFF; m_en_act = 8'hFF;
      m_pend = 1'b0; q_vld = 1'b0; q_we = 1'b0; q_addr = 2'd0; q_wdata = 32'h0;
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ready = 1'b0; exp_rd = 1'b0;
      exp_rdata = 32'h0;
    end else begin
      slot = m_t % SD;
      d    = (m_t / SD) % 8;
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
      if (slot >= BL && m_en_act[d]) begin
        exp_an[d] = 1'b0;
        exp_seg   = glyph(m_data_act[4*d +: 4]);
        exp_dp    = ~m_dpm_act[d];
      end
      exp_ready = q_vld;
      exp_rd    = q_vld && !q_we;
      exp_rdata = 32'h0;
      if (exp_rd) begin
        case (q_addr)
          2'd0: exp_rdata = m_data_sh;
          2'd1: exp_rdata = {24'h0, m_dpm_sh};
          2'd2: exp_rdata = {24'h0, m_en_sh};
          default: exp_rdata = {28'h0, m_pend, d[2:0]};
        endcase
      end
      if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
        m_data_act = m_data_sh; m_dpm_act = m_dpm_sh; m_en_act = m_en_sh;
        m_pend = 1'b0;
      end
      if (q_vld && q_we && q_addr != 2'd3) begin
        if (q_addr == 2'd0) m_data_sh = q_wdata;
        if (q_addr == 2'd1) m_dpm_sh  = q_wdata[7:0];
        if (q_addr == 2'd2) m_en_sh   = q_wdata[7:0];
        m_pend = 1'b1;
      end
      q_vld = sel; q_we = we; q_addr = addr; q_wdata = wdata;
      m_t++;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("cyc_an", {24'h0, an}, {24'h0, exp_an});
      chk("cyc_seg", {25'h0, seg}, {25'h0, exp_seg});
      chk("cyc_dp", {31'h0, dp}, {31'h0, exp_dp});
      chk("cyc_ready", {31'h0, ready}, {31'h0, exp_ready});
      if (exp_rd) chk("cyc_rdata", rdata, exp_rdata);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] d, output logic [31:0] rd);
    sel = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("ready_lat", {31'h0, ready}, 32'h1);
    rd = rdata;
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m_t % FRAME) != ph && n < 200);
    if ((m_t % FRAME) != ph) begin
      checks++; errors++;
      $display("FAIL wait_phase: phase %0d not reached, at %0d", ph, m_t % FRAME);
    end
  endtask

  task automatic capture_frame(input string tag, input logic [31:0] data,
                               input logic [7:0] en, input logic [7:0] dpm);
    int on_cnt [8];
    int blank_cnt, other_cnt, glyph_bad, dp_bad, n_en;
    bit hit;
    logic [7:0] oh;
    for (int i = 0; i < 8; i++) on_cnt[i] = 0;
    blank_cnt = 0; other_cnt = 0; glyph_bad = 0; dp_bad = 0; n_en = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (an === 8'hFF) begin
        blank_cnt++;
        if (seg !== 7'h7F) glyph_bad++;
        if (dp !== 1'b1) dp_bad++;
      end else begin
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
          oh = 8'h01 << i;
          if (an === ~oh) begin
            hit = 1'b1;
            on_cnt[i]++;
            if (seg !== glyph(data[4*i +: 4])) glyph_bad++;
            if (dp !== ~dpm[i]) dp_bad++;
          end
        end
        if (!hit) other_cnt++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (en[i]) n_en++;
      chk($sformatf("%s_on%0d", tag, i), on_cnt[i], en[i] ? 32'd3 : 32'd0);
    end
    chk({tag, "_blank"}, blank_cnt, 32'(FRAME - 3 * n_en));
    chk({tag, "_other_an"}, other_cnt, 32'd0);
    chk({tag, "_glyph"}, glyph_bad, 32'd0);
    chk({tag, "_dp"}, dp_bad, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_dp", {31'h0, dp}, 32'h1);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    rst = 1'b0;
    bus(1'b0, 2'd3, 32'h0, rd);
    chk("rst_status", rd, 32'h0);

    // Write DATA then read it back on the very next cycle
    sel = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'h7654_3210;
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = 2'd0;
    @(negedge clk);
    sel = 1'b0;
    chk("wr_ready", {31'h0, ready}, 32'h1);
    @(negedge clk);
    chk("rd_ready", {31'h0, ready}, 32'h1);
    chk("rd_data", rdata, 32'h7654_3210);
    bus(1'b0, 2'd3, 32'h0, rd);
    chk("status_pending", {31'h0, rd[3]}, 32'h1);
    bus(1'b1, 2'd3, 32'hFFFF_FFFF, rd);   // ignored
    bus(1'b0, 2'd1, 32'h0, rd);
    chk("dpm_read", rd, 32'h0);

    // First committed frame shows digits 0..7
    wait_phase(1);
    capture_frame("frame_hex", 32'h7654_3210, 8'hFF, 8'h00);

    // Partial enable plus decimal point on digit 0
    bus(1'b1, 2'd2, 32'hFFFF_FF0F, rd);
    bus(1'b1, 2'd1, 32'h0000_0101, rd);
    bus(1'b0, 2'd2, 32'h0, rd);
    chk("en_read_masked", rd, 32'h0F);
    wait_phase(1);
    capture_frame("frame_en", 32'h7654_3210, 8'h0F, 8'h01);

    // Re-enable all, then write DATA exactly in the commit cycle
    bus(1'b1, 2'd2, 32'h0000_00FF, rd);
    wait_phase(FRAME - 2);
    bus(1'b1, 2'd0, 32'hFFFF_FFFF, rd);
    bus(1'b0, 2'd3, 32'h0, rd);
    chk("status_still_pending", rd, 32'h8);
    wait_phase(22);                         // shows state idx 5, cnt 1
    chk("old_an5", {24'h0, an}, 32'hDF);
    chk("old_seg5", {25'h0, seg}, 32'h12);
    wait_phase(1);
    capture_frame("frame_f", 32'hFFFF_FFFF, 8'hFF, 8'h01);
    bus(1'b0, 2'd3, 32'h0, rd);
    chk("status_cleared", rd, 32'h0);

    // Reset mid-slot at idx 5 with a read in flight
    wait_phase(21);
    sel = 1'b1; we = 1'b0; addr = 2'd0;
    @(negedge clk);
    sel = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", {24'h0, an}, 32'hFF);
    chk("mid_rst_seg", {25'h0, seg}, 32'h7F);
    chk("mid_rst_dp", {31'h0, dp}, 32'h1);
    chk("mid_rst_ready", {31'h0, ready}, 32'h0);
    rst = 1'b0;
    bus(1'b0, 2'd3, 32'h0, rd);
    chk("post_rst_status", rd, 32'h0);
    @(negedge clk);                         // shows state idx 0, cnt 2
    chk("post_rst_an", {24'h0, an}, 32'hFE);
    chk("post_rst_seg", {25'h0, seg}, 32'h40);
    bus(1'b0, 2'd0, 32'h0, rd);
    chk("post_rst_data", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Memory-mapped scan controller for the board's 8-digit, common-anode seven-segment display. It sits on the SoC peripheral bus beside the LED register. It time-multiplexes the shared CA–CG/DP segment lines across the eight anodes, with inter-digit blanking for ghost suppression. Software writes are double-buffered and committed only at frame boundaries, so the display never tears.

## Interface
Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz). Must satisfy SCAN_DIV ≥ BLANK+2.
- BLANK, 16: cycles at the start of each slot with all anodes off.

Ports:
- CLK100MHZ  in  1  system clock; sole clock.
- RESET  in  1  synchronous, active-high reset.
- sel  in  1  bus access strobe, one cycle per access.
- we  in  1  write enable, qualified by sel.
- addr  in  2  word index: 0 DATA, 1 DPMASK, 2 ENABLE, 3 STATUS.
- wdata  in  32  write data.
- rdata  out  32  read data, valid when ready=1.
- ready  out  1  access-complete pulse.
- CA, CB, CC, CD, CE, CF, CG  out  1 each  segment lines, active-low.
- DP  out  1  decimal point, active-low.
- AN  out  8  anodes, active-low; AN[i] drives digit i.

## Operation
- Shadow registers are bus-writable:
  - DATA: 32 bits; digit i = bits 4i+3:4i, hex value.
  - DPMASK: bits 7:0; 1 = point lit.
  - ENABLE: bits 7:0; 1 = digit shown.
- Each shadow register has an active copy, which drives the display.
- Any shadow write sets `pending`.
- Commit event: the cycle in which the slot counter wraps with digit index 7→0. If `pending` is set, all active copies load from shadow and `pending` clears.
- Write coinciding with a commit: active copies take the pre-write shadow values, and `pending` stays set, so the new value commits at the next frame.
- STATUS read: {28'b0, pending, idx[2:0]}. Writes to addr 3 are ignored and do not set `pending`.
- Reads of 0–2 return shadow values. Bit widths above the defined fields read 0, and writes to those bits are discarded.
- Scan state:
  - Slot counter cnt runs 0..SCAN_DIV-1, then wraps to 0 and increments idx (mod 8).
  - Phase BLANK (cnt < BLANK): AN=8'hFF, segments all 1.
  - Phase SHOW (cnt ≥ BLANK): AN[idx]=0 if active ENABLE[idx], else AN=8'hFF.
  - In SHOW, segments = hex decode of active digit idx and DP = ~active DPMASK[idx], gated off when the digit is disabled.
- Hex decode uses the standard 0–F glyphs (b and d lowercase).
- Reset values:
  - AN=8'hFF, CA–CG=1, DP=1, rdata=0, ready=0.
  - cnt=0, idx=0, pending=0.
  - DATA=0 and DPMASK=0 (shadow and active); ENABLE=8'hFF (shadow and active).
- RESET asserted mid-slot or mid-access returns every register to its reset value on the next edge. An access in flight gets no ready.

## Timing
- All outputs are registered.
- Bus access: sel at edge N produces ready=1 with rdata valid for exactly the cycle after edge N+1. One access is accepted per cycle; back-to-back sel gives back-to-back ready.
- A write's shadow value is visible to a read issued the very next cycle.
- Display outputs lag the (cnt, idx) state by one cycle.
- Anode switch sequence: AN goes to FF in the first output cycle of a slot, so two anodes are never low simultaneously.
- Frame period = 8·SCAN_DIV cycles.
- Commit latency from a write: up to 8·SCAN_DIV cycles.

## Structure
- Shared package sevenseg_pkg holds:
  - register index constants (ADDR_DATA=0, ADDR_DPMASK=1, ADDR_ENABLE=2, ADDR_STATUS=3);
  - the 16-entry hex-to-segment constant table (7-bit, active-low, order {CG..CA});
  - the all-off segment constant.
- One combinational sub-module, sevenseg_decoder: 4-bit hex in, 7 active-low segment bits out.
- Bus register file, commit logic and scan FSM stay in the top of this block.

## Test plan
Benches run with SCAN_DIV=4 and BLANK=1.
- Reset: hold RESET 3 cycles, then check AN=FF, CA–CG=1, DP=1, ready=0. Read STATUS → 0x0.
- Write DATA=0x76543210, then read DATA on the next cycle → 0x76543210, ready one cycle after each sel. STATUS bit 3 reads 1.
- After the commit, capture a full frame. Each digit i shows glyph i, with AN one-hot-low at bit i for 3 cycles and FF for 1 cycle between digits.
- Write ENABLE=0x0F and DPMASK=0x01, wait one frame. AN[7:4] are never low; DP=0 only while AN[0]=0.
- Write DATA=0xFFFFFFFF in the exact commit cycle. Display keeps the old values for one more frame and shows "F" on all digits after the following commit; pending clears then.
- Assert RESET while idx=5 and mid-slot. The next cycle shows reset values, and scanning restarts at idx 0 with DATA=0.
